// File: rtl/serial_axi_pkg.sv
// serial_axi_pkg: shared types and constants for the serial IP AXI4-lite master
package serial_axi_pkg;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_CONTROL = 4'h8;
    localparam logic [3:0] REG_BRD     = 4'hC;

    typedef struct packed {
        state_t      state;
        logic        cmd_ready;
        logic        awvalid;
        logic        wvalid;
        logic        bready;
        logic        arvalid;
        logic        rready;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic [1:0]  rsp_resp;
        logic        rsp_timeout;
    } ctrl_t;

endpackage

// File: rtl/serial_axi_master.sv
// serial_axi_master: one-at-a-time command/response to AXI4-lite initiator with phase timeout
module serial_axi_master
    import serial_axi_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_TIMEOUT          = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    input  logic [3:0]                    cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int CW = C_TIMEOUT > 0 ? $clog2(C_TIMEOUT + 1) : 1;

    ctrl_t                         q, d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          busy, expired;

    assign busy    = q.state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign expired = C_TIMEOUT != 0 && busy && cnt_q + CW'(1) == CW'(C_TIMEOUT);

    // next-state and next-output values; every output is taken from a flop
    always_comb begin
        d      = q;
        addr_d = addr_q;
        case (q.state)
            IDLE: if (cmd_valid) begin
                addr_d        = cmd_addr;
                d.wdata       = cmd_wdata;
                d.wstrb       = cmd_wstrb;
                d.write       = cmd_write;
                d.rsp_rdata   = '0;
                d.rsp_resp    = RESP_OKAY;
                d.rsp_timeout = 1'b0;
                d.cmd_ready   = 1'b0;
                d.awvalid     = cmd_write;
                d.wvalid      = cmd_write;
                d.arvalid     = !cmd_write;
                d.state       = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                d.awvalid = q.awvalid && !M_AXI_AWREADY;
                d.wvalid  = q.wvalid && !M_AXI_WREADY;
                if (!d.awvalid && !d.wvalid) begin
                    d.bready = 1'b1;
                    d.state  = WR_RESP;
                end
            end
            WR_RESP: if (M_AXI_BVALID) begin
                d.bready    = 1'b0;
                d.rsp_resp  = M_AXI_BRESP;
                d.rsp_valid = 1'b1;
                d.state     = RESP;
            end
            RD_REQ: if (M_AXI_ARREADY) begin
                d.arvalid = 1'b0;
                d.rready  = 1'b1;
                d.state   = RD_RESP;
            end
            RD_RESP: if (M_AXI_RVALID) begin
                d.rready    = 1'b0;
                d.rsp_rdata = M_AXI_RDATA;
                d.rsp_resp  = M_AXI_RRESP;
                d.rsp_valid = 1'b1;
                d.state     = RESP;
            end
            RESP: if (rsp_ready) begin
                d.rsp_valid = 1'b0;
                d.cmd_ready = 1'b1;
                d.state     = IDLE;
            end
            default: d.state = IDLE;
        endcase
        if (expired) begin
            d.awvalid     = 1'b0;
            d.wvalid      = 1'b0;
            d.bready      = 1'b0;
            d.arvalid     = 1'b0;
            d.rready      = 1'b0;
            d.rsp_rdata   = '0;
            d.rsp_resp    = RESP_SLVERR;
            d.rsp_timeout = 1'b1;
            d.rsp_valid   = 1'b1;
            d.state       = RESP;
        end
        cnt_d = d.state != q.state ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
    end

    // state, payload and phase counter registers
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            q      <= '{state: IDLE, cmd_ready: 1'b1, default: '0};
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            q      <= d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cmd_ready     = q.cmd_ready;
    assign rsp_valid     = q.rsp_valid;
    assign rsp_write     = q.write;
    assign rsp_rdata     = q.rsp_rdata;
    assign rsp_resp      = q.rsp_resp;
    assign rsp_timeout   = q.rsp_timeout;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = q.awvalid;
    assign M_AXI_WDATA   = q.wdata;
    assign M_AXI_WSTRB   = q.wstrb;
    assign M_AXI_WVALID  = q.wvalid;
    assign M_AXI_BREADY  = q.bready;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = q.arvalid;
    assign M_AXI_RREADY  = q.rready;

endmodule

// File: tb/tb_serial_axi_master.sv
// tb_serial_axi_master: table vectors, corner sequences and random traffic against a register slave model
module tb_serial_axi_master;
    import serial_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;

    int          errors = 0, checks = 0;
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic        dead = 1'b0;
    logic [1:0]  sl_resp = RESP_OKAY;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw0, w0, b0, ar0, r0;
    logic [31:0] ref_mem [4];

    always #5 clk = ~clk;

    serial_axi_master #(.C_M_AXI_ADDR_WIDTH(4), .C_TIMEOUT(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // slave register file: byte-lane merge of a write
    logic        aw_got, w_got, ar_got;
    logic [3:0]  aw_a, ar_a, ws;
    logic [31:0] wd;
    logic [31:0] mem [4];
    int          aw_w, w_w, b_w, ar_w, r_w;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] dd, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = dd[8*i +: 8];
        return r;
    endfunction

    // AXI4-lite slave with programmable ready/response delays; "dead" never answers
    always @(posedge clk) begin
        if (rst) begin
            {awready, wready, arready, bvalid, rvalid, aw_got, w_got, ar_got} <= '0;
            {aw_w, w_w, b_w, ar_w, r_w} <= '0;
            bresp <= '0; rresp <= '0; rdata <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (awvalid && awready) begin awready <= 1'b0; aw_got <= 1'b1; aw_a <= awaddr; end
            else if (awvalid && !dead) begin if (aw_w >= aw_dly) begin awready <= 1'b1; aw_w <= 0; end else aw_w <= aw_w + 1; end
            if (wvalid && wready) begin wready <= 1'b0; w_got <= 1'b1; wd <= wdata; ws <= wstrb; end
            else if (wvalid && !dead) begin if (w_w >= w_dly) begin wready <= 1'b1; w_w <= 0; end else w_w <= w_w + 1; end
            if (aw_got && w_got && !bvalid) begin
                if (b_w >= b_dly) begin
                    bvalid <= 1'b1; bresp <= sl_resp; b_w <= 0; aw_got <= 1'b0; w_got <= 1'b0;
                    mem[aw_a[3:2]] <= merge(mem[aw_a[3:2]], wd, ws);
                end else b_w <= b_w + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin arready <= 1'b0; ar_got <= 1'b1; ar_a <= araddr; end
            else if (arvalid && !dead) begin if (ar_w >= ar_dly) begin arready <= 1'b1; ar_w <= 0; end else ar_w <= ar_w + 1; end
            if (ar_got && !rvalid) begin
                if (r_w >= r_dly) begin
                    rvalid <= 1'b1; rdata <= mem[ar_a[3:2]]; rresp <= sl_resp; r_w <= 0; ar_got <= 1'b0;
                end else r_w <= r_w + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // handshake counters seen on the bus
    always @(posedge clk) begin
        if (!rst) begin
            if (awvalid && awready) aw_hs <= aw_hs + 1;
            if (wvalid && wready)   w_hs  <= w_hs + 1;
            if (bvalid && bready)   b_hs  <= b_hs + 1;
            if (arvalid && arready) ar_hs <= ar_hs + 1;
            if (rvalid && rready)   r_hs  <= r_hs + 1;
        end
    end

    function automatic logic [31:0] ref_write(input logic [31:0] o, input logic [31:0] dd, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (dd & m);
    endfunction

    function automatic logic [36:0] rsp_vec();
        return {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout};
    endfunction

    function automatic logic [19:0] hs_delta();
        return {4'(aw_hs - aw0), 4'(w_hs - w0), 4'(b_hs - b0), 4'(ar_hs - ar0), 4'(r_hs - r0)};
    endfunction

    task automatic snap();
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // issue a command at a falling edge and wait for the response; lat counts edges after acceptance
    task automatic txn(input logic w, input logic [3:0] a, input logic [31:0] dd, input logic [3:0] s,
                       output int lat, output logic skew);
        int n;
        cmd_write = w; cmd_addr = a; cmd_wdata = dd; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", n < 50, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        skew = 1'b0;
        while (!rsp_valid && lat < 100) begin
            if (awvalid && !wvalid) skew = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic fin();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  sr;
        logic [31:0] er;
    } vec_t;

    initial begin
        vec_t        tbl [9];
        int          lat, n;
        logic        skew;
        logic [36:0] p;
        tbl[0] = '{1'b1, REG_CONTROL, 32'h0000_0055, 4'hF, RESP_OKAY,   32'h0};
        tbl[1] = '{1'b0, REG_CONTROL, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0055};
        tbl[2] = '{1'b1, REG_BRD,     32'h0000_1234, 4'hF, RESP_OKAY,   32'h0};
        tbl[3] = '{1'b0, REG_BRD,     32'h0,         4'h0, RESP_OKAY,   32'h0000_1234};
        tbl[4] = '{1'b1, REG_CONTROL, 32'hAABB_CCDD, 4'h5, RESP_OKAY,   32'h0};
        tbl[5] = '{1'b0, REG_CONTROL, 32'h0,         4'h0, RESP_OKAY,   32'h00BB_00DD};
        tbl[6] = '{1'b1, REG_DATA,    32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 32'h0};
        tbl[7] = '{1'b0, REG_DATA,    32'h0,         4'h0, RESP_DECERR, 32'hDEAD_BEEF};
        tbl[8] = '{1'b0, REG_STATUS,  32'h0,         4'h0, RESP_OKAY,   32'h0};
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("reset_ctl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready}, 6'b100000);
        chk("reset_rsp", rsp_vec(), 37'h0);
        chk("reset_addr", {awaddr, araddr, wstrb}, 12'h0);
        chk("reset_wdata", wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            sl_resp = tbl[i].sr;
            snap();
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, lat, skew);
            chk($sformatf("vec%0d_rsp", i), rsp_vec(), {1'b1, tbl[i].w, tbl[i].er, tbl[i].sr, 1'b0});
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_handshakes", i), hs_delta(), tbl[i].w ? 20'h11100 : 20'h00011);
            if (tbl[i].w) ref_mem[tbl[i].a[3:2]] = ref_write(ref_mem[tbl[i].a[3:2]], tbl[i].d, tbl[i].s);
            fin();
        end
        sl_resp = RESP_OKAY;

        aw_dly = 3;
        snap();
        txn(1'b1, REG_STATUS, 32'hCAFE_F00D, 4'hF, lat, skew);
        chk("skew_wvalid_drop", skew, 1);
        chk("skew_handshakes", hs_delta(), 20'h11100);
        chk("skew_rsp", rsp_vec(), {1'b1, 1'b1, 32'h0, RESP_OKAY, 1'b0});
        ref_mem[1] = ref_write(ref_mem[1], 32'hCAFE_F00D, 4'hF);
        fin();
        aw_dly = 0;

        txn(1'b0, REG_BRD, 32'h0, 4'h0, lat, skew);
        p = rsp_vec();
        chk("bp_first", p, {1'b1, 1'b0, ref_mem[3], RESP_OKAY, 1'b0});
        snap();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i), {rsp_vec(), cmd_ready, awvalid, wvalid, arvalid, bready, rready}, {p, 6'b0});
        end
        chk("bp_no_axi", hs_delta(), 20'h0);
        fin();

        dead = 1'b1;
        snap();
        cmd_write = 1'b0; cmd_addr = REG_STATUS; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (arvalid && n < 100) begin n++; @(negedge clk); end
        chk("tmo_cycles", n, 16);
        chk("tmo_rsp", rsp_vec(), {1'b1, 1'b0, 32'h0, 2'b10, 1'b1});
        chk("tmo_handshakes", hs_delta(), 20'h0);
        fin();
        dead = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [1:0]  idx;
            logic [31:0] dd;
            logic [3:0]  s;
            int          r;
            w = 1'($urandom_range(0, 1));
            idx = 2'($urandom_range(0, 3));
            dd = $urandom;
            s = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 2);
            sl_resp = r == 0 ? RESP_OKAY : r == 1 ? RESP_SLVERR : RESP_DECERR;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            snap();
            txn(w, {idx, 2'b00}, dd, s, lat, skew);
            chk($sformatf("rnd%0d_rsp", i), rsp_vec(), {1'b1, w, w ? 32'h0 : ref_mem[idx], sl_resp, 1'b0});
            chk($sformatf("rnd%0d_handshakes", i), hs_delta(), w ? 20'h11100 : 20'h00011);
            if (w) ref_mem[idx] = ref_write(ref_mem[idx], dd, s);
            fin();
        end
        {aw_dly, w_dly, ar_dly, r_dly} = '0;
        sl_resp = RESP_OKAY;

        b_dly = 3;
        snap();
        cmd_write = 1'b1; cmd_addr = REG_CONTROL; cmd_wdata = 32'h77; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (aw_hs == aw0 && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_aw_seen", n < 20, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 7'b0000001);
        chk("rst_mid_rsp", rsp_vec(), 37'h0);
        rst = 1'b0;
        b_dly = 0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_completion", {rsp_valid, 4'(b_hs - b0)}, 5'h0);
        txn(1'b0, REG_CONTROL, 32'h0, 4'h0, lat, skew);
        chk("rst_after_read", rsp_vec(), {1'b1, 1'b0, ref_mem[2], RESP_OKAY, 1'b0});
        chk("rst_after_latency", lat, 4);
        fin();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/serial_axi_master.md
# serial_axi_master

AXI4-lite initiator that turns simple command/response transactions into single AXI4-lite register reads and writes. It is the bus-master counterpart of the serial IP register slave, with register offsets DATA 0x0, STATUS 0x4, CONTROL 0x8 and BRD 0xC. It sits between a local controller (test sequencer, bring-up FSM, or soft-core glue) and the serial IP's S_AXI port. Only one transaction is outstanding at a time, and a cycle-count timeout keeps a dead slave from hanging the controller.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width; matches the slave's address width.
- C_TIMEOUT, 256, cycles allowed per AXI phase before abort; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata / cmd_wstrb  in  32 / 4  write data and byte enables.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction was aborted by the timeout.
- M_AXI_AWADDR, AWPROT(3, always 3'b000), AWVALID out; AWREADY in.
- M_AXI_WDATA(32), WSTRB(4), WVALID out; WREADY in.
- M_AXI_BRESP(2), BVALID in; BREADY out.
- M_AXI_ARADDR, ARPROT(3, always 3'b000), ARVALID out; ARREADY in.
- M_AXI_RDATA(32), RRESP(2), RVALID in; RREADY out.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
- IDLE:
  - cmd_ready = 1; no other state asserts cmd_ready.
  - On cmd_valid, register addr, wdata, wstrb and write.
  - Go to WR_REQ for a write, RD_REQ for a read.
- WR_REQ:
  - AWVALID and WVALID rise together, because the slave needs both valid before it asserts either ready.
  - Each valid drops independently on its own handshake (xVALID && xREADY at the clock edge).
  - Once both handshakes have completed, go to WR_RESP. Handshakes in the same or different cycles are both legal.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP and go to RESP.
- RD_REQ: ARVALID held until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY = 1. On RVALID, capture RDATA and RRESP and go to RESP.
- RESP: rsp_valid held with stable payload until rsp_ready, then go to IDLE.
- Address, data and strobe outputs stay stable while their valid is high.
- Timeout:
  - A counter clears on every state entry and increments in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches C_TIMEOUT, all AXI valid/ready outputs drop, rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0, and the FSM goes to RESP.
  - This abort is a deliberate protocol exit for a dead slave; the slave's state is undefined afterwards.
- Error responses (SLVERR/DECERR) pass through unchanged with rsp_timeout = 0.

## Timing
- Reset values: state IDLE; cmd_ready = 1; rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_resp = 0, rsp_timeout = 0; all AXI valid/ready outputs 0; AWADDR, ARADDR, WDATA, WSTRB = 0.
- Reset asserted mid-transaction returns every output to its reset value at the next edge, with no completion and no response.
- Write latency: command accepted at edge N → AWVALID/WVALID high from N+1.
  - Against the serial slave, which answers AW/W in 1 cycle and B in 1 more, rsp_valid rises at N+4.
- Read latency: ARVALID high from N+1; ARREADY at N+2; RREADY high from N+2; RVALID at N+3; rsp_valid from N+4.
- All outputs are registered; there is no combinational path from AXI inputs to AXI outputs.
- Back-to-back throughput: with rsp_ready tied high, the next command is accepted one cycle after the response handshake (IDLE lasts ≥1 cycle).

## Structure
- Package serial_axi_pkg holds:
  - the state enum;
  - response constants: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - serial register offsets: DATA 0x0, STATUS 0x4, CONTROL 0x8, BRD 0xC.
- Single module with no sub-module; the timeout counter is inline (width $clog2(C_TIMEOUT+1)).

## Test plan
- Write CONTROL: addr 0x8, wdata 0x0000_0055, wstrb 0xF, against the serial slave → one AW and one W handshake; rsp_resp = 00, rsp_write = 1; a later read of 0x8 returns 0x55.
- Read BRD after writing 0x0000_1234 → rsp_rdata = 0x0000_1234, rsp_resp = 00, rsp_valid exactly 4 cycles after the command handshake.
- Skewed write slave: AWREADY 3 cycles after WREADY → WVALID drops after its handshake while AWVALID stays high; exactly one B handshake follows.
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid and payload stay stable, cmd_ready = 0 throughout, and no new AXI activity occurs.
- Timeout: C_TIMEOUT = 16, ARREADY tied 0 → ARVALID drops after 16 cycles; rsp_resp = 10, rsp_timeout = 1, rsp_rdata = 0.
- Reset mid-write, after AW handshake and before B → next edge: AWVALID = WVALID = BREADY = 0, rsp_valid = 0, cmd_ready = 1; a subsequent read completes normally.
